// File: rtl/snake_path_queue.sv
// snake_path_queue: move sequencer and body queue for a grid snake game.
//
// The head position lives in registers. The body cells, oldest first, live in
// a circular queue of MAX_LEN-1 usable entries. Each accepted move takes one
// ISSUE cycle. During that cycle the tick strobe presents the pending move to
// an external occupancy map. The map answers with self_hit_now, which is
// sampled at the edge that ends ISSUE.
//
// Ports:
//   clk, reset_n          rising-edge clock, asynchronous active-low reset
//   step_req, dir, eat    move request, direction (00 up, 01 right, 10 down,
//                         11 left) and grow flag; sampled in IDLE only
//   self_hit_now          collision answer from the occupancy map
//   tick                  one-cycle strobe marking the pending move
//   head_xy, tail_xy      head cell and oldest body cell, packed as {x,y}
//   next_x, next_y        target cell of the pending move
//   will_pop, eat_o       tail cell vacates on this tick, and its inverse
//   length                body count plus head
//   ready, game_over      idle indicator and sticky death flag
//
// Configuration macro: SNAKE_WRAP_EN. When it is defined, moves wrap around
// the grid edges. When it is undefined, a move off the grid kills the snake.
module snake_path_queue #(
  parameter int GRID_W  = 8,
  parameter int GRID_H  = 6,
  parameter int XW      = 3,
  parameter int YW      = 3,
  parameter int AW      = 4,
  parameter int MAX_LEN = 16,
  parameter int START_X = 2,
  parameter int START_Y = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 step_req,
  input  logic [1:0]           dir,
  input  logic                 eat,
  input  logic                 self_hit_now,
  output logic                 tick,
  output logic [XW+YW-1:0]     head_xy,
  output logic [XW+YW-1:0]     tail_xy,
  output logic [XW-1:0]        next_x,
  output logic [YW-1:0]        next_y,
  output logic                 will_pop,
  output logic                 eat_o,
  output logic [AW:0]          length,
  output logic                 ready,
  output logic                 game_over
);

`ifdef SNAKE_WRAP_EN
  localparam logic WRAP_EN = 1'b1;
`else
  localparam logic WRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE = 2'b00, ISSUE = 2'b01, DEAD = 2'b10} state_t;

  state_t                state_r, state_nxt_s;
  logic [XW-1:0]         head_x_r;
  logic [YW-1:0]         head_y_r;
  logic [1:0]            cur_dir_r;
  logic                  eat_q_r;
  logic [AW-1:0]         count_r, wr_ptr_r, rd_ptr_r;
  logic                  game_over_r;
  logic [XW+YW-1:0]      mem_r [MAX_LEN];

  logic [1:0]            filt_dir_s;
  logic                  cand_off_s;
  logic                  will_pop_s;
  logic [XW-1:0]         nxt_x_s;
  logic [YW-1:0]         nxt_y_s;

  // Target cell for a move from (x,y) in direction d, wrapped at the grid edges.
  function automatic logic [XW+YW-1:0] step_target(input logic [XW-1:0] x,
                                                   input logic [YW-1:0] y,
                                                   input logic [1:0] d);
    logic [XW-1:0] nx;
    logic [YW-1:0] ny;
    nx = x;
    ny = y;
    case (d)
      2'b00:   ny = (y == '0) ? YW'(GRID_H - 1) : y - YW'(1);
      2'b01:   nx = (x == XW'(GRID_W - 1)) ? XW'(0) : x + XW'(1);
      2'b10:   ny = (y == YW'(GRID_H - 1)) ? YW'(0) : y + YW'(1);
      2'b11:   nx = (x == '0) ? XW'(GRID_W - 1) : x - XW'(1);
      default: nx = x;
    endcase
    return {nx, ny};
  endfunction

  // A move counts as off-grid only when the grid does not wrap.
  function automatic logic off_grid(input logic [XW-1:0] x,
                                    input logic [YW-1:0] y,
                                    input logic [1:0] d);
    logic edge_hit;
    case (d)
      2'b00:   edge_hit = (y == '0);
      2'b01:   edge_hit = (x == XW'(GRID_W - 1));
      2'b10:   edge_hit = (y == YW'(GRID_H - 1));
      2'b11:   edge_hit = (x == '0);
      default: edge_hit = 1'b0;
    endcase
    return edge_hit & ~WRAP_EN;
  endfunction

  // Direction filter: a reversal is ignored once a body exists, because it
  // would run the head straight into the neck.
  always_comb begin
    filt_dir_s = dir;
    if ((dir == (cur_dir_r ^ 2'b10)) && (count_r != '0)) begin
      filt_dir_s = cur_dir_r;
    end else begin
      filt_dir_s = dir;
    end
    cand_off_s = off_grid(head_x_r, head_y_r, filt_dir_s);
    {nxt_x_s, nxt_y_s} = step_target(head_x_r, head_y_r, cur_dir_r);
    // A full queue cannot grow, so eating when full still vacates the tail.
    will_pop_s = ~eat_q_r | (count_r == AW'(MAX_LEN - 1));
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (step_req) begin
          state_nxt_s = cand_off_s ? DEAD : ISSUE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE:   state_nxt_s = self_hit_now ? DEAD : IDLE;
      DEAD:    state_nxt_s = DEAD;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, head, direction, queue pointers and death flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      head_x_r    <= XW'(START_X);
      head_y_r    <= YW'(START_Y);
      cur_dir_r   <= 2'b01;
      eat_q_r     <= 1'b0;
      count_r     <= '0;
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      game_over_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (state_nxt_s == DEAD) begin
        game_over_r <= 1'b1;
      end
      if ((state_r == IDLE) && step_req && !cand_off_s) begin
        cur_dir_r <= filt_dir_s;
        eat_q_r   <= eat;
      end
      if ((state_r == ISSUE) && !self_hit_now) begin
        head_x_r <= nxt_x_s;
        head_y_r <= nxt_y_s;
        wr_ptr_r <= wr_ptr_r + AW'(1);
        if (will_pop_s) begin
          rd_ptr_r <= rd_ptr_r + AW'(1);
        end else begin
          count_r  <= count_r + AW'(1);
        end
      end
    end
  end

  // Body storage: the old head is pushed when a move commits. No reset needed.
  always_ff @(posedge clk) begin
    if ((state_r == ISSUE) && !self_hit_now) begin
      mem_r[wr_ptr_r] <= {head_x_r, head_y_r};
    end
  end

  assign tick      = (state_r == ISSUE);
  assign ready     = (state_r == IDLE);
  assign game_over = game_over_r;
  assign head_xy   = {head_x_r, head_y_r};
  assign tail_xy   = (count_r == '0) ? {head_x_r, head_y_r} : mem_r[rd_ptr_r];
  assign next_x    = nxt_x_s;
  assign next_y    = nxt_y_s;
  assign will_pop  = will_pop_s;
  assign eat_o     = ~will_pop_s;
  assign length    = {1'b0, count_r} + (AW+1)'(1);

endmodule

// File: doc/snake_path_queue.md
SNAKE_PATH_QUEUE -- requirements
Module: snake_path_queue

Interface
REQ-001 Parameters SHALL be: GRID_W, default 8, grid columns; GRID_H, default 6, grid rows; XW, default 3, x width; YW, default 3, y width; AW, default 4, log2(MAX_LEN); MAX_LEN, default 16, body-queue depth (2**AW); START_X, default 2; START_Y, default 2.
REQ-002 One clock, reset asynchronous and active-low: clk, input, 1, rising-edge clock; reset_n, input, 1, async active-low reset.
REQ-003 step_req, input, 1, request one snake move; sampled only in IDLE.
REQ-004 dir, input, 2, requested direction: 00 up (y-1), 01 right (x+1), 10 down (y+1), 11 left (x-1).
REQ-005 eat, input, 1, grow on this move; sampled with step_req.
REQ-006 self_hit_now, input, 1, collision flag from the occupancy map; sampled at the clock edge that ends ISSUE.
REQ-007 tick, output, 1, one-cycle occupancy-map update strobe.
REQ-008 head_xy, output, XW+YW, current head {x,y}; tail_xy, output, XW+YW, oldest body cell {x,y}.
REQ-009 next_x, output, XW, and next_y, output, YW, give the head target of the pending move.
REQ-010 will_pop, output, 1, tail cell vacates on this tick; eat_o, output, 1, equals ~will_pop.
REQ-011 length, output, AW+1, snake length including head; ready, output, 1, high in IDLE; game_over, output, 1, sticky death flag.

Function
REQ-012 The FSM SHALL have three states: IDLE, ISSUE and DEAD.
REQ-013 IDLE with step_req=1 SHALL latch eat into eat_q, latch the filtered direction into cur_dir, and move to ISSUE.
REQ-014 A direction exactly opposite cur_dir SHALL be ignored (cur_dir kept) when length>1; it SHALL be accepted when length==1.
REQ-015 In ISSUE, tick SHALL be 1 for exactly one cycle with next_x, next_y, will_pop, eat_o, head_xy and tail_xy stable all cycle.
REQ-016 next_x/next_y SHALL be combinational from head and cur_dir.
REQ-017 will_pop SHALL equal ~eat_q OR (count==MAX_LEN-1), where count is the body-cell count; eating when full SHALL not grow the snake.
REQ-018 When count==0, tail_xy SHALL equal head_xy.
REQ-019 At the edge ending ISSUE with self_hit_now=0:
  - head SHALL become next;
  - the old head SHALL be pushed at the write pointer;
  - the read pointer SHALL advance if will_pop;
  - count SHALL change by +1 or 0;
  - the FSM SHALL return to IDLE.
REQ-020 Simultaneous push and pop SHALL leave count unchanged; when count==0 the just-pushed entry SHALL be popped, so length stays 1.
REQ-021 At the edge ending ISSUE with self_hit_now=1, the FSM SHALL go to DEAD, set game_over=1, and leave head, pointers and count unchanged.
REQ-022 DEAD SHALL ignore step_req, hold tick=0 and ready=0, and be left only by reset.
REQ-023 Move latency SHALL be fixed: step_req accepted at edge N, tick high in cycle N+1, new head_xy visible after edge N+2, ready high again in cycle N+2.
REQ-024 length SHALL equal count+1.
REQ-025 Pointers SHALL wrap modulo MAX_LEN.

Reset
REQ-026 reset_n low SHALL asynchronously force: state IDLE, head=(START_X,START_Y), cur_dir=01, count=0, pointers=0, eat_q=0, tick=0, game_over=0.
REQ-027 Reset asserted mid-ISSUE SHALL abort the move with no queue update; tick SHALL drop immediately.
REQ-028 Queue storage SHALL need no reset.

Configuration
REQ-029 With SNAKE_WRAP_EN defined, moves off the grid SHALL wrap: x=GRID_W-1 plus right gives 0, x=0 plus left gives GRID_W-1, and y likewise with GRID_H.
REQ-030 Without SNAKE_WRAP_EN, an accepted step whose target is off-grid SHALL go from IDLE directly to DEAD, with game_over=1, no tick, and no state change.

Verification
REQ-031 Reset, GRID 8x6 -> head_xy=(2,2), tail_xy=(2,2), length=1, tick=0, ready=1, game_over=0.
REQ-032 Two steps, dir=01, eat=1 -> one tick per step with will_pop=0, head (4,2), tail (2,2), length 3.
REQ-033 Step dir=01, eat=0 -> during tick: next=(5,2), will_pop=1, tail_xy=(2,2); afterwards head (5,2), tail (3,2), length 3.
REQ-034 Length 3 heading right, step dir=11 -> reversal ignored, next=(6,2).
REQ-035 Head (7,2), step dir=01 -> with SNAKE_WRAP_EN next=(0,2) and a tick; without it game_over=1 and no tick.
REQ-036 self_hit_now=1 during tick -> game_over=1, head_xy unchanged, subsequent step_req produces no tick until reset_n pulses low.
